neo_watchdog_gen: RTL and testbench

Parametrised NEO-B1 watchdog. It decodes the 68k write to $300001 as a kick and runs a configurable-width timeout counter. On expiry or on a window violation it drives nRESET/nHALT low for a programmable number of WDCLK cycles, and it records the cause in sticky status. It replaces the fixed 4-bit watchdog on the B1 side of the system and is clocked by the frame-rate WDCLK.

---
 rtl/neo_wdt_pkg.sv | 19 +
 rtl/neo_wdt_kick_sync.sv | 39 +++
 rtl/neo_watchdog_gen.sv | 113 +++++++++++
 tb/tb_neo_watchdog_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/neo_wdt_pkg.sv
// Shared definitions for the NEO-B1 watchdog: FSM states, bite cause codes
// and the $300001 kick-write decode constants.
package neo_wdt_pkg;

   typedef enum logic {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } wdt_state_e;

   localparam logic [1:0] CAUSE_POR     = 2'b00;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
   localparam logic [1:0] CAUSE_EARLY   = 2'b10;

   // $300001: A23=0, A22=0, A21..A17 = 1,1,0,0,0, lower byte strobe, write
   localparam logic       KICK_A23    = 1'b0;
   localparam logic       KICK_A22    = 1'b0;
   localparam logic [4:0] KICK_ADDR_U = 5'b11000;

endpackage

// File: rtl/neo_wdt_kick_sync.sv
// Stretches the short 68k kick strobe and brings it into the WDCLK domain
// as a single-cycle kick_pulse.
module neo_wdt_kick_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic kick_raw,
   output logic kick_pulse
);

   logic kick_req_q, kick_req_d;
   logic s1_q, s2_q, s3_q;

   // The request is held until it has been seen at the second sync stage
   always_comb begin
      kick_req_d = kick_req_q;
      if (s2_q) kick_req_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n or posedge kick_raw) begin
      if (!rst_n)        kick_req_q <= 1'b0;
      else if (kick_raw) kick_req_q <= 1'b1;
      else               kick_req_q <= kick_req_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= kick_req_q;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign kick_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/neo_watchdog_gen.sv
// NEO-B1 watchdog: $300001 kick decode, HOLD/RUN FSM with timeout and
// early-kick window, sticky bite cause and saturating bite counter.
module neo_watchdog_gen
   import neo_wdt_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int TIMEOUT    = 8,
   parameter int HOLD       = 8,
   parameter int WINDOW_MIN = 0
) (
   input  logic         WDCLK,
   input  logic         nRST,
   input  logic         nLDS,
   input  logic         RW,
   input  logic         A23I,
   input  logic         A22I,
   input  logic [21:17] M68K_ADDR_U,
   input  logic         EN,
   input  logic         WIN_MODE,
   output logic         nRESET,
   output logic         nHALT,
   output logic [1:0]   WD_CAUSE,
   output logic [7:0]   FIRE_CNT
);

   localparam int                HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

   logic kick_raw, kick_pulse, early_kick;

   assign kick_raw = nRST & ~nLDS & ~RW & (A23I == KICK_A23) & (A22I == KICK_A22) &
                     (M68K_ADDR_U == KICK_ADDR_U);

   neo_wdt_kick_sync u_kick_sync (
      .clk        (WDCLK),
      .rst_n      (nRST),
      .kick_raw   (kick_raw),
      .kick_pulse (kick_pulse)
   );

   wdt_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [1:0]        cause_q, cause_d;
   logic [7:0]        fire_cnt_q, fire_cnt_d;
   logic              nreset_q, nreset_d;

   assign early_kick = WIN_MODE && (WINDOW_MIN > 0) && (int'(count_q) < WINDOW_MIN);

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      count_d    = count_q;
      cause_d    = cause_q;
      fire_cnt_d = fire_cnt_q;
      case (state_q)
         ST_HOLD: begin
            count_d = '0;
            if (hold_cnt_q == HOLD_LAST) begin
               state_d    = ST_RUN;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         default: begin
            // A kick landing on the expiry edge beats the timeout
            if (kick_pulse && early_kick) begin
               state_d = ST_HOLD;
               cause_d = CAUSE_EARLY;
            end else if (kick_pulse || !EN) begin
               count_d = '0;
            end else if (count_q == CNT_LAST) begin
               state_d = ST_HOLD;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
            if (state_d == ST_HOLD) begin
               count_d    = '0;
               hold_cnt_d = '0;
               if (fire_cnt_q != 8'hFF) fire_cnt_d = fire_cnt_q + 8'd1;
            end
         end
      endcase
      nreset_d = (state_d == ST_RUN);
   end

   always_ff @(posedge WDCLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= ST_HOLD;
         hold_cnt_q <= '0;
         count_q    <= '0;
         cause_q    <= CAUSE_POR;
         fire_cnt_q <= 8'd0;
         nreset_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         count_q    <= count_d;
         cause_q    <= cause_d;
         fire_cnt_q <= fire_cnt_d;
         nreset_q   <= nreset_d;
      end
   end

   assign nRESET   = nreset_q;
   assign nHALT    = nreset_q;
   assign WD_CAUSE = cause_q;
   assign FIRE_CNT = fire_cnt_q;

endmodule

// File: tb/tb_neo_watchdog_gen.sv
// Directed and randomized bench for neo_watchdog_gen, checked against an
// edge-indexed reference model of the watchdog rules.
module tb_neo_watchdog_gen;

   localparam int T    = 8;
   localparam int H    = 8;
   localparam int WMIN = 3;

   logic        WDCLK = 1'b0;
   logic        nRST = 1'b0;
   logic        nLDS = 1'b1, RW = 1'b1, A23I = 1'b0, A22I = 1'b0;
   logic [21:17] M68K_ADDR_U = 5'b00000;
   logic        EN = 1'b1, WIN_MODE = 1'b0;
   logic        nRESET, nHALT;
   logic [1:0]  WD_CAUSE;
   logic [7:0]  FIRE_CNT;

   neo_watchdog_gen #(.CNT_W(8), .TIMEOUT(T), .HOLD(H), .WINDOW_MIN(WMIN)) dut (
      .WDCLK(WDCLK), .nRST(nRST), .nLDS(nLDS), .RW(RW), .A23I(A23I), .A22I(A22I),
      .M68K_ADDR_U(M68K_ADDR_U), .EN(EN), .WIN_MODE(WIN_MODE),
      .nRESET(nRESET), .nHALT(nHALT), .WD_CAUSE(WD_CAUSE), .FIRE_CNT(FIRE_CNT)
   );

   always #50 WDCLK = ~WDCLK;

   int errors = 0;
   int checks = 0;
   int ed = 0;

   // Reference model: elapsed-edge counters plus a queue of edges on which
   // each accepted kick becomes effective (3rd edge after the write).
   bit m_run;
   int m_hold, m_idle, m_fire;
   int m_cause;
   int dueq[$];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, ed);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_hold = 0; m_idle = 0; m_cause = 0; m_fire = 0;
      dueq.delete();
   endtask

   task automatic model_bite(input int c);
      m_run = 0; m_hold = 0; m_cause = c;
      if (m_fire < 255) m_fire++;
   endtask

   task automatic model_step();
      bit kick;
      while (dueq.size() > 0 && dueq[0] < ed) void'(dueq.pop_front());
      kick = (dueq.size() > 0 && dueq[0] == ed);
      if (kick) void'(dueq.pop_front());
      if (!m_run) begin
         m_hold++;
         if (m_hold == H) begin m_run = 1; m_idle = 0; end
      end else if (kick && WIN_MODE && m_idle < WMIN) model_bite(2);
      else if (kick || !EN) m_idle = 0;
      else if (m_idle == T - 1) model_bite(1);
      else m_idle++;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge WDCLK);
         ed++;
         model_step();
         #1;
         chk("nreset", 8'(nRESET), 8'(m_run));
         chk("nhalt", 8'(nHALT), 8'(m_run));
         chk("cause", 8'(WD_CAUSE), 8'(m_cause));
         chk("fire", FIRE_CNT, 8'(m_fire));
      end
   endtask

   // bad: 0 valid, 1 read, 2 nLDS high, 3 A17 set, 4 A23I set
   task automatic do_kick(input int bad);
      #10;
      nLDS = (bad == 2); RW = (bad == 1); A23I = (bad == 4); A22I = 1'b0;
      M68K_ADDR_U = (bad == 3) ? 5'b11001 : 5'b11000;
      if (bad == 0) dueq.push_back(ed + 3);
      #20;
      nLDS = 1'b1; RW = 1'b1; A23I = 1'b0; M68K_ADDR_U = 5'b00000;
   endtask

   task automatic do_reset();
      #10;
      nRST = 1'b0;
      model_reset();
      #1;
      chk("rst_nreset", 8'(nRESET), 8'd0);
      chk("rst_nhalt", 8'(nHALT), 8'd0);
      chk("rst_cause", 8'(WD_CAUSE), 8'd0);
      chk("rst_fire", FIRE_CNT, 8'd0);
      #10;
      nRST = 1'b1;
   endtask

   initial begin
      int gap;
      // power-on: release, no kicks
      do_reset();
      tick(7);
      chk("por_low7", 8'(nRESET), 8'd0);
      tick(1);
      chk("por_rise8", 8'(nRESET), 8'd1);
      tick(7);
      chk("por_high15", 8'(nRESET), 8'd1);
      tick(1);
      chk("por_bite16", 8'(nRESET), 8'd0);
      chk("por_cause", 8'(WD_CAUSE), 8'd1);
      chk("por_fire", FIRE_CNT, 8'd1);

      // periodic kicks every 4 cycles
      do_reset();
      tick(8);
      repeat (25) begin do_kick(0); tick(4); end
      chk("per_nreset", 8'(nRESET), 8'd1);
      chk("per_fire", FIRE_CNT, 8'd0);

      // window: count held at 0 by EN=0, released so the kick lands at count 1
      do_reset();
      EN = 1'b0; WIN_MODE = 1'b1;
      tick(10);
      do_kick(0);
      tick(1);
      EN = 1'b1;
      tick(2);
      chk("win_early_nreset", 8'(nRESET), 8'd0);
      chk("win_early_cause", 8'(WD_CAUSE), 8'd2);
      chk("win_early_fire", FIRE_CNT, 8'd1);
      tick(8);
      chk("win_rerun", 8'(nRESET), 8'd1);
      tick(3);
      do_kick(0);
      tick(3);
      chk("win_ok_nreset", 8'(nRESET), 8'd1);
      chk("win_ok_fire", FIRE_CNT, 8'd1);
      tick(7);
      chk("win_ok_high", 8'(nRESET), 8'd1);
      tick(1);
      chk("win_to_cause", 8'(WD_CAUSE), 8'd1);
      chk("win_to_nreset", 8'(nRESET), 8'd0);
      WIN_MODE = 1'b0;

      // decode negatives leave bite timing unchanged
      do_reset();
      tick(8);
      for (int b = 1; b <= 4; b++) begin do_kick(b); tick(2); end
      chk("neg_bite", 8'(nRESET), 8'd0);
      chk("neg_cause", 8'(WD_CAUSE), 8'd1);

      // kick on the expiry edge, then kick during HOLD
      do_reset();
      tick(13);
      do_kick(0);
      tick(3);
      chk("sim_nobite", 8'(nRESET), 8'd1);
      chk("sim_fire0", FIRE_CNT, 8'd0);
      tick(7);
      chk("sim_high", 8'(nRESET), 8'd1);
      tick(1);
      chk("sim_bite", 8'(nRESET), 8'd0);
      tick(1);
      do_kick(0);
      tick(14);
      chk("hold_kick_high", 8'(nRESET), 8'd1);
      tick(1);
      chk("hold_kick_bite", 8'(nRESET), 8'd0);
      chk("hold_kick_fire", FIRE_CNT, 8'd2);

      // reset in mid-bite, then saturation
      do_reset();
      tick(19);
      do_reset();
      tick(7);
      chk("mid_low7", 8'(nRESET), 8'd0);
      tick(1);
      chk("mid_rise8", 8'(nRESET), 8'd1);
      tick(300 * 16);
      chk("sat_fire", FIRE_CNT, 8'd255);

      // randomized kicks, bad decodes, EN and WIN_MODE toggles
      do_reset();
      gap = 0;
      repeat (600) begin
         int r;
         tick(1);
         gap++;
         r = int'($urandom_range(0, 9));
         if (gap >= 4 && r < 4) begin
            do_kick((r == 0) ? int'($urandom_range(1, 4)) : 0);
            gap = 0;
         end
         if ($urandom_range(0, 19) == 0) EN = ~EN;
         if ($urandom_range(0, 29) == 0) WIN_MODE = ~WIN_MODE;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
